// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: pipelined MIPS execute stage feeding the EX/MEM register.
// Optional iterative MULT/MULTU into HI/LO is built when EXEC_MULDIV_EN is defined.
module execute_stage_pipe #(
    parameter int DW   = 32,
    parameter int IMMW = 26
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic [DW-1:0]   i_pc,
    input  logic [IMMW-1:0] i_imm,
    input  logic [DW-1:0]   i_op1,
    input  logic [DW-1:0]   i_op2,
    input  logic            i_ALUSrc,
    input  logic [1:0]      i_ALUop,
    input  logic            i_extOp,
    input  logic            i_jump,
    input  logic            i_beq,
    input  logic            i_bne,
    output logic            o_valid,
    output logic [DW-1:0]   o_ALUres,
    output logic [DW-1:0]   o_op2,
    output logic [DW-1:0]   o_nextPC,
    output logic            o_pcsrc,
    output logic            o_busy
);
    logic [5:0]    w_funct;
    logic [15:0]   w_imm16;
    logic [DW-1:0] w_sext, w_op2, w_diff, w_pc4, w_btgt, w_jtgt, w_res;
    logic [DW-1:0] w_hi, w_lo, w_mul_lo;
    logic          w_zero, w_pcsrc, w_accept, w_is_mul, w_mul_done;

    assign w_funct  = i_imm[5:0];
    assign w_imm16  = i_imm[15:0];
    assign w_sext   = {{(DW-16){w_imm16[15]}}, w_imm16};
    assign w_op2    = i_ALUSrc ? (i_extOp ? w_sext : {{(DW-16){1'b0}}, w_imm16}) : i_op2;
    assign w_diff   = i_op1 - w_op2;
    assign w_zero   = (w_diff == '0);
    assign w_pc4    = i_pc + DW'(4);
    assign w_btgt   = w_pc4 + (w_sext << 2);
    assign w_jtgt   = {w_pc4[DW-1:28], i_imm[25:0], 2'b00};
    assign w_pcsrc  = i_jump | (i_beq & w_zero) | (i_bne & ~w_zero);
    assign w_accept = i_valid & o_ready & ~i_flush;

    // ALU result selection; unknown funct codes yield zero
    always_comb begin
        w_res = '0;
        case (i_ALUop)
            2'b00:   w_res = i_op1 + w_op2;
            2'b01:   w_res = w_diff;
            2'b11:   w_res = i_op1 | w_op2;
            default: begin
                case (w_funct)
                    6'h20:   w_res = i_op1 + w_op2;
                    6'h22:   w_res = w_diff;
                    6'h24:   w_res = i_op1 & w_op2;
                    6'h25:   w_res = i_op1 | w_op2;
                    6'h2A:   w_res = {{(DW-1){1'b0}}, $signed(i_op1) < $signed(w_op2)};
                    6'h10:   w_res = w_hi;
                    6'h12:   w_res = w_lo;
                    default: w_res = '0;
                endcase
            end
        endcase
    end

`ifdef EXEC_MULDIV_EN
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_prod, r_mcand, w_prod_fin;
    logic [DW-1:0]   r_mplier, r_hi, r_lo, w_abs1, w_abs2;
    logic            r_neg, w_sgn;

    assign w_is_mul   = (i_ALUop == 2'b10) & (w_funct[5:1] == 5'b01100);
    assign w_sgn      = (w_funct == 6'h18);
    assign w_abs1     = (w_sgn & i_op1[DW-1]) ? -i_op1 : i_op1;
    assign w_abs2     = (w_sgn & i_op2[DW-1]) ? -i_op2 : i_op2;
    assign w_prod_fin = r_neg ? -r_prod : r_prod;
    assign w_mul_lo   = w_prod_fin[DW-1:0];
    assign w_mul_done = (r_state == DONE);
    assign w_hi       = r_hi;
    assign w_lo       = r_lo;
    assign o_busy     = (r_state != IDLE);
    assign o_ready    = (r_state == IDLE) & ~i_stall;

    // Multiply FSM: unsigned shift-add on magnitudes, sign fixed up when HI/LO are written
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept & w_is_mul) begin
                        r_state  <= MUL;
                        r_cnt    <= '0;
                        r_prod   <= '0;
                        r_mcand  <= {{DW{1'b0}}, w_abs1};
                        r_mplier <= w_abs2;
                        r_neg    <= w_sgn & (i_op1[DW-1] ^ i_op2[DW-1]);
                    end
                end
                MUL: begin
                    if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == CW'(DW-1)) r_state <= DONE;
                    else r_cnt <= r_cnt + CW'(1);
                end
                DONE: begin
                    if (!i_stall) begin
                        r_state      <= IDLE;
                        {r_hi, r_lo} <= w_prod_fin;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_lo   = '0;
    assign w_hi       = '0;
    assign w_lo       = '0;
    assign o_busy     = 1'b0;
    assign o_ready    = ~i_stall;
`endif

    // EX/MEM register: flush kills, stall freezes, a finished multiply presents LO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_ALUres <= '0;
            o_op2    <= '0;
            o_nextPC <= '0;
            o_pcsrc  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (!i_stall) begin
            if (w_mul_done) begin
                o_valid  <= 1'b1;
                o_ALUres <= w_mul_lo;
            end else begin
                o_valid <= w_accept & ~w_is_mul;
                if (w_accept) begin
                    o_ALUres <= w_res;
                    o_op2    <= i_op2;
                    o_nextPC <= i_jump ? w_jtgt : w_btgt;
                    o_pcsrc  <= w_pcsrc;
                end
            end
        end
    end
endmodule
